// File: rtl/tl_router_param.sv
// tl_router_param: routes words from one input FIFO to N_PORTS output FIFOs selected by each word's top bits.
// Ports: i_clk, i_reset (async, active-low); i_init holds INIT and captures i_umbral_alto/i_umbral_bajo;
//   i_push_in/i_data_in write the input FIFO; i_pop_out[k] pops port k onto o_data_out[k*DATA_W +: DATA_W];
//   o_out_empty/o_out_almost_full/o_out_almost_empty and o_in_full/o_in_empty are FIFO flags;
//   i_req/i_idx read a per-port pop counter on o_counter_out/o_counter_valid; o_state, o_error_out report the FSM.
module tl_router_param #(
   parameter int DATA_W     = 12,
   parameter int N_PORTS    = 4,
   parameter int IN_AW      = 2,
   parameter int OUT_AW     = 3,
   parameter int CNT_W      = 5,
   parameter int STALL_MODE = 0,
   localparam int SEL_W     = $clog2(N_PORTS),
   localparam int TH_W      = OUT_AW + 1
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_init,
   input  logic [TH_W-1:0]             i_umbral_alto,
   input  logic [TH_W-1:0]             i_umbral_bajo,
   input  logic                        i_push_in,
   input  logic [DATA_W-1:0]           i_data_in,
   input  logic [N_PORTS-1:0]          i_pop_out,
   output logic [N_PORTS*DATA_W-1:0]   o_data_out,
   output logic [N_PORTS-1:0]          o_out_empty,
   output logic [N_PORTS-1:0]          o_out_almost_full,
   output logic [N_PORTS-1:0]          o_out_almost_empty,
   output logic                        o_in_full,
   output logic                        o_in_empty,
   input  logic                        i_req,
   input  logic [SEL_W-1:0]            i_idx,
   output logic [CNT_W-1:0]            o_counter_out,
   output logic                        o_counter_valid,
   output logic [2:0]                  o_state,
   output logic                        o_error_out
);
   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;
   state_t r_state, w_next;
   logic [DATA_W-1:0] r_in_mem [2**IN_AW];
   logic [IN_AW-1:0] r_in_wp, r_in_rp;
   logic [IN_AW:0] r_in_cnt, w_in_cnt_nxt;
   logic [TH_W-1:0] r_alto, r_bajo;
   logic r_cv;
   logic [CNT_W-1:0] r_co;
   logic w_run, w_pop_ok, w_push, w_route, w_stall, w_flush, w_any, w_rd;
   logic [DATA_W-1:0] w_head;
   logic [SEL_W-1:0] w_dest;
   logic [N_PORTS-1:0] w_full, w_nz;
   logic [N_PORTS-1:0][CNT_W-1:0] w_pop_cnt;
   assign w_run = r_state == ST_IDLE || r_state == ST_ACTIVE;
   assign w_pop_ok = w_run || r_state == ST_ERROR;
   assign w_head = r_in_mem[r_in_rp];
   assign w_dest = w_head[DATA_W-1 -: SEL_W];
   // count is one bit wider than the pointers, so its MSB alone marks a full FIFO
   assign o_in_full = r_in_cnt[IN_AW];
   assign o_in_empty = r_in_cnt == '0;
   assign w_push = w_run && i_push_in && !o_in_full;
   assign w_stall = (STALL_MODE != 0) ? o_out_almost_full[w_dest] : |o_out_almost_full;
   assign w_route = w_run && !o_in_empty && !w_full[w_dest] && !w_stall;
   assign w_in_cnt_nxt = r_in_cnt + (IN_AW+1)'(w_push) - (IN_AW+1)'(w_route);
   // IDLE/ACTIVE follow the contents the FIFOs will hold after this edge
   assign w_any = w_in_cnt_nxt != '0 || |w_nz;
   assign w_flush = w_next == ST_INIT;
   assign w_rd = i_req && r_state == ST_IDLE;
   assign o_state = r_state;
   assign o_error_out = r_state == ST_ERROR;
   assign o_counter_out = r_co;
   assign o_counter_valid = r_cv;
   always_comb begin
      w_next = r_state;
      if (r_state != ST_RESET && i_push_in && o_in_full) w_next = ST_ERROR;
      else if (r_state == ST_RESET) w_next = ST_INIT;
      else if (r_state == ST_INIT) w_next = i_init ? ST_INIT : ST_IDLE;
      else if (w_run) w_next = i_init ? ST_INIT : (w_any ? ST_ACTIVE : ST_IDLE);
      else w_next = ST_ERROR;
   end
   always_ff @(posedge i_clk) if (w_push) r_in_mem[r_in_wp] <= i_data_in;
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_RESET;
         r_in_wp <= '0;
         r_in_rp <= '0;
         r_in_cnt <= '0;
         r_alto <= '0;
         r_bajo <= '0;
         r_cv <= 1'b0;
         r_co <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_INIT) begin
            r_alto <= i_umbral_alto;
            r_bajo <= i_umbral_bajo;
         end
         r_cv <= w_rd;
         r_co <= w_rd ? w_pop_cnt[i_idx] : '0;
         if (w_flush) begin
            r_in_wp <= '0;
            r_in_rp <= '0;
            r_in_cnt <= '0;
         end else begin
            if (w_push) r_in_wp <= r_in_wp + IN_AW'(1);
            if (w_route) r_in_rp <= r_in_rp + IN_AW'(1);
            r_in_cnt <= w_in_cnt_nxt;
         end
      end
   end
   for (genvar k = 0; k < N_PORTS; k++) begin : g_port
      logic [DATA_W-1:0] r_mem [2**OUT_AW];
      logic [OUT_AW-1:0] r_wp, r_rp;
      logic [TH_W-1:0] r_cnt, w_cnt_nxt;
      logic [CNT_W-1:0] r_pops;
      logic [DATA_W-1:0] r_dout;
      logic w_in, w_out;
      assign w_in = w_route && w_dest == SEL_W'(k);
      assign w_out = i_pop_out[k] && r_cnt != '0 && w_pop_ok;
      assign w_cnt_nxt = r_cnt + TH_W'(w_in) - TH_W'(w_out);
      assign w_full[k] = r_cnt[OUT_AW];
      assign w_nz[k] = w_cnt_nxt != '0;
      assign w_pop_cnt[k] = r_pops;
      assign o_out_empty[k] = r_cnt == '0;
      assign o_out_almost_full[k] = r_cnt >= r_alto;
      assign o_out_almost_empty[k] = r_cnt <= r_bajo;
      assign o_data_out[k*DATA_W +: DATA_W] = r_dout;
      always_ff @(posedge i_clk) if (w_in) r_mem[r_wp] <= w_head;
      always_ff @(posedge i_clk or negedge i_reset) begin
         if (!i_reset) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
            r_pops <= '0;
            r_dout <= '0;
         end else begin
            if (w_out) r_dout <= r_mem[r_rp];
            if (w_flush) begin
               r_wp <= '0;
               r_rp <= '0;
               r_cnt <= '0;
               r_pops <= '0;
            end else begin
               if (w_in) r_wp <= r_wp + OUT_AW'(1);
               if (w_out) r_rp <= r_rp + OUT_AW'(1);
               if (w_out) r_pops <= r_pops + CNT_W'(1);
               r_cnt <= w_cnt_nxt;
            end
         end
      end
   end
endmodule

// File: tb/tb_tl_router_param.sv
// tb_tl_router_param: directed scoreboard bench driving a global-stall and a per-destination-stall router in lockstep.
module tb_tl_router_param;
   logic clk = 0, reset = 1, init = 0, push = 0, req = 0;
   logic [3:0] alto = 4'd6, bajo = 4'd0, pop = '0;
   logic [11:0] din = '0;
   logic [1:0] idx = '0;
   logic [47:0] dout [2];
   logic [3:0] oe [2], oaf [2], oae [2];
   logic ifull [2], iempty [2], cv [2], err [2];
   logic [4:0] co [2];
   logic [2:0] st [2];
   logic [11:0] q [8][$];
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   tl_router_param #(.STALL_MODE(0)) dut0 (
      .i_clk(clk), .i_reset(reset), .i_init(init), .i_umbral_alto(alto), .i_umbral_bajo(bajo),
      .i_push_in(push), .i_data_in(din), .i_pop_out(pop), .o_data_out(dout[0]), .o_out_empty(oe[0]),
      .o_out_almost_full(oaf[0]), .o_out_almost_empty(oae[0]), .o_in_full(ifull[0]), .o_in_empty(iempty[0]),
      .i_req(req), .i_idx(idx), .o_counter_out(co[0]), .o_counter_valid(cv[0]), .o_state(st[0]), .o_error_out(err[0]));
   tl_router_param #(.STALL_MODE(1)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_init(init), .i_umbral_alto(alto), .i_umbral_bajo(bajo),
      .i_push_in(push), .i_data_in(din), .i_pop_out(pop), .o_data_out(dout[1]), .o_out_empty(oe[1]),
      .o_out_almost_full(oaf[1]), .o_out_almost_empty(oae[1]), .o_in_full(ifull[1]), .o_in_empty(iempty[1]),
      .i_req(req), .i_idx(idx), .o_counter_out(co[1]), .o_counter_valid(cv[1]), .o_state(st[1]), .o_error_out(err[1]));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, act, exp);
      end
   endtask
   task automatic put(input logic [11:0] w, input bit sb);
      push = 1;
      din = w;
      if (sb) begin
         q[int'(w[11:10])].push_back(w);
         q[4 + int'(w[11:10])].push_back(w);
      end
      tick();
      push = 0;
   endtask
   task automatic pop_n(input int k, input int n);
      pop[k] = 1;
      repeat (n) tick();
      pop[k] = 0;
   endtask
   task automatic rd(input logic [1:0] i, input logic [4:0] e);
      req = 1;
      idx = i;
      tick();
      req = 0;
      for (int d = 0; d < 2; d++) begin
         chk("cnt_valid", d, cv[d], 1);
         chk("cnt_value", d, co[d], e);
      end
   endtask
   for (genvar d = 0; d < 2; d++) begin : g_mon
      logic [3:0] pend;
      logic [11:0] e;
      initial forever begin
         @(negedge clk);
         pend = pop & ~oe[d];
         @(posedge clk);
         #2;
         for (int k = 0; k < 4; k++) if (pend[k]) begin
            n_tests++;
            if (q[d*4+k].size() == 0) begin
               n_fail++;
               $display("FAIL sb_extra dut%0d port%0d: got %0h, expected no word", d, k, dout[d][k*12 +: 12]);
            end else begin
               e = q[d*4+k].pop_front();
               if (dout[d][k*12 +: 12] !== e) begin
                  n_fail++;
                  $display("FAIL sb_data dut%0d port%0d: got %0h, expected %0h", d, k, dout[d][k*12 +: 12], e);
               end
            end
         end
      end
   end
   initial begin
      #1 reset = 0;
      repeat (2) tick();
      for (int d = 0; d < 2; d++) begin
         chk("rst_state", d, st[d], 0);
         chk("rst_out_empty", d, oe[d], 4'hF);
         chk("rst_almost_full", d, oaf[d], 4'hF);
         chk("rst_almost_empty", d, oae[d], 4'hF);
         chk("rst_in_empty", d, iempty[d], 1);
         chk("rst_in_full", d, ifull[d], 0);
         chk("rst_error", d, err[d], 0);
         chk("rst_cnt_valid", d, cv[d], 0);
         chk("rst_cnt_out", d, co[d], 0);
         chk("rst_data_out", d, dout[d], 0);
      end
      reset = 1;
      init = 1;
      tick();
      for (int d = 0; d < 2; d++) chk("init_enter", d, st[d], 1);
      repeat (2) tick();
      init = 0;
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("idle_state", d, st[d], 2);
         chk("thr_alto", d, oaf[d], 4'h0);
         chk("thr_bajo", d, oae[d], 4'hF);
      end
      for (int i = 1; i <= 7; i++) put(12'(i), 1);
      repeat (2) tick();
      for (int d = 0; d < 2; d++) begin
         chk("fill_almost_full", d, oaf[d], 4'b0001);
         chk("fill_out_empty", d, oe[d], 4'b1110);
         chk("fill_almost_empty", d, oae[d], 4'b1110);
         chk("fill_in_empty", d, iempty[d], 0);
         chk("fill_active", d, st[d], 3);
      end
      pop_n(0, 7);
      for (int d = 0; d < 2; d++) begin
         chk("drain_idle", d, st[d], 2);
         chk("drain_out_empty", d, oe[d], 4'hF);
         chk("drain_in_empty", d, iempty[d], 1);
      end
      rd(0, 7);
      rd(1, 0);
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("rd_off_valid", d, cv[d], 0);
         chk("rd_off_value", d, co[d], 0);
      end
      put(12'h801, 1);
      req = 1;
      idx = 0;
      put(12'h802, 1);
      req = 0;
      for (int d = 0; d < 2; d++) chk("rd_active_valid", d, cv[d], 0);
      put(12'h803, 1);
      put(12'h804, 1);
      pop_n(2, 1);
      pop_n(2, 2);
      for (int d = 0; d < 2; d++) chk("xfer_pop_cnt2_left1", d, oe[d][2], 0);
      pop_n(2, 1);
      for (int d = 0; d < 2; d++) chk("xfer_pop_cnt2_left0", d, oe[d][2], 1);
      rd(2, 4);
      for (int i = 0; i < 32; i++) begin
         put(12'h400 | 12'(i), 1);
         tick();
         pop_n(1, 1);
         if (i == 30) rd(1, 31);
         if (i == 31) rd(1, 0);
      end
      for (int i = 1; i <= 6; i++) put(12'h020 + 12'(i), 1);
      repeat (2) tick();
      for (int d = 0; d < 2; d++) chk("m1_almost_full", d, oaf[d], 4'b0001);
      put(12'h400, 1);
      repeat (3) tick();
      chk("m1_global_block", 0, oe[0][1], 1);
      chk("m1_global_in_empty", 0, iempty[0], 0);
      chk("m1_perdest_pass", 1, oe[1][1], 0);
      chk("m1_perdest_in_empty", 1, iempty[1], 1);
      put(12'h027, 1);
      put(12'h401, 1);
      repeat (3) tick();
      pop_n(1, 1);
      tick();
      chk("m1_head_block", 1, oe[1][1], 1);
      chk("m1_head_in_empty", 1, iempty[1], 0);
      chk("m1_global_in_empty2", 0, iempty[0], 0);
      pop_n(0, 7);
      repeat (2) tick();
      pop_n(1, 2);
      for (int d = 0; d < 2; d++) begin
         chk("m1_done_empty", d, oe[d], 4'hF);
         chk("m1_done_in_empty", d, iempty[d], 1);
         chk("m1_done_idle", d, st[d], 2);
      end
      for (int i = 0; i < 10; i++) put(12'h010 + 12'(i), i < 6);
      for (int d = 0; d < 2; d++) begin
         chk("ovf_in_full", d, ifull[d], 1);
         chk("ovf_no_error_yet", d, err[d], 0);
         chk("ovf_active", d, st[d], 3);
      end
      put(12'h01A, 0);
      for (int d = 0; d < 2; d++) begin
         chk("ovf_error", d, err[d], 1);
         chk("ovf_state", d, st[d], 4);
      end
      pop_n(0, 6);
      for (int d = 0; d < 2; d++) begin
         chk("err_drain_empty", d, oe[d][0], 1);
         chk("err_sticky", d, st[d], 4);
         chk("err_no_route", d, iempty[d], 0);
      end
      #2 reset = 0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("async_state", d, st[d], 0);
         chk("async_error", d, err[d], 0);
         chk("async_in_empty", d, iempty[d], 1);
         chk("async_in_full", d, ifull[d], 0);
         chk("async_out_empty", d, oe[d], 4'hF);
         chk("async_data_out", d, dout[d], 0);
      end
      foreach (q[i]) q[i].delete();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
